// File: rtl/mac_act_unit.sv
// -----------------------------------------------------------------------------
// mac_act_unit
//
// Multiply-accumulate datapath with ReLU + requantization into a small
// activation buffer (the hidden-layer store that feeds the next round).
//
//   Stage P : prod_q  <= x_in * w_in (full 2*DATA_W signed), prod_v_q <= ~mac_clear
//   Stage A : acc_q   <= sat(acc_q + sext(prod_q)) when prod_v_q && !mac_clear
//   Write   : entry k <= f(acc_q) on every edge where we[k] is high
//   Read    : rd_data <= entry[rd_addr] (one-edge latency, read-before-write)
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset
//   mac_clear  in   1        synchronous clear of pipeline, accumulator, count
//   x_in       in   DATA_W   signed activation operand
//   w_in       in   DATA_W   signed weight operand
//   relu_en    in   1        1 = clamp negative accumulator to 0 before shift
//   we         in   NUM_ENT  one-hot write strobe into the activation buffer
//   rd_addr    in   log2(NUM_ENT)  buffer read address
//   rd_data    out  DATA_W   registered read data
//   acc_out    out  ACC_W    accumulator register (debug)
//   mac_count  out  8        products accumulated since last clear, saturating
//   we_multi   out  1        sticky flag: more than one we bit seen high
// -----------------------------------------------------------------------------
module mac_act_unit #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 24,
    parameter int FRAC_SHIFT = 4,
    parameter int NUM_ENT    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mac_clear,
    input  logic [DATA_W-1:0]          x_in,
    input  logic [DATA_W-1:0]          w_in,
    input  logic                       relu_en,
    input  logic [NUM_ENT-1:0]         we,
    input  logic [$clog2(NUM_ENT)-1:0] rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [ACC_W-1:0]           acc_out,
    output logic [7:0]                 mac_count,
    output logic                       we_multi
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int HI_W   = ACC_W - DATA_W + 1;

    localparam logic [ACC_W-1:0]   ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]   ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]  ACT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]  ACT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [NUM_ENT-1:0] WE_ONE  = {{(NUM_ENT-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Stage P: product register
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] x_ext;
    logic [PROD_W-1:0] w_ext;
    logic [PROD_W-1:0] prod_d;
    logic [PROD_W-1:0] prod_q;
    logic              prod_v_q;

    // Sign-extend both operands to the product width; the low PROD_W bits
    // of the two's-complement product are then exact.
    assign x_ext  = {{DATA_W{x_in[DATA_W-1]}}, x_in};
    assign w_ext  = {{DATA_W{w_in[DATA_W-1]}}, w_in};
    assign prod_d = x_ext * w_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
        end else if (mac_clear) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            prod_v_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage A: saturating accumulator and product counter
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;
    logic [ACC_W:0]   sum_w;

    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign sum_w = {acc_q[ACC_W-1], acc_q}
                 + {{(ACC_W+1-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (mac_clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (prod_v_q) begin
            if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
                acc_d = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_d = sum_w[ACC_W-1:0];
            end
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Activation: optional ReLU, arithmetic shift, clamp to DATA_W
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]  relu_v;
    logic [ACC_W-1:0]  shr_v;
    logic [HI_W-1:0]   shr_hi;
    logic [DATA_W-1:0] act_v;

    assign relu_v = (relu_en && acc_q[ACC_W-1]) ? '0 : acc_q;
    assign shr_v  = $signed(relu_v) >>> FRAC_SHIFT;
    // The value fits DATA_W only if every bit from the DATA_W sign position
    // upward is a copy of the sign.
    assign shr_hi = shr_v[ACC_W-1:DATA_W-1];

    always_comb begin
        act_v = shr_v[DATA_W-1:0];
        if (!((&shr_hi) || (~|shr_hi))) begin
            act_v = shr_v[ACC_W-1] ? ACT_MIN : ACT_MAX;
        end
    end

    // ------------------------------------------------------------------
    // Activation buffer: registers (every entry must clear on rst)
    // ------------------------------------------------------------------
    logic [NUM_ENT-1:0][DATA_W-1:0] ent_all;

    for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_ent
        logic [DATA_W-1:0] ent_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ent_q <= '0;
            end else if (we[gi]) begin
                ent_q <= act_v;
            end
        end

        assign ent_all[gi] = ent_q;
    end

    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= ent_all[rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Sticky multi-write detector: we & (we-1) clears the lowest set bit,
    // so anything left over means two or more strobes.
    // ------------------------------------------------------------------
    logic we_many;
    logic we_multi_q;

    assign we_many = |(we & (we - WE_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_multi_q <= 1'b0;
        end else if (we_many) begin
            we_multi_q <= 1'b1;
        end
    end

    assign rd_data   = rd_data_q;
    assign acc_out   = acc_q;
    assign mac_count = cnt_q;
    assign we_multi  = we_multi_q;

endmodule

// File: tb/tb_mac_act_unit.sv
// -----------------------------------------------------------------------------
// tb_mac_act_unit
//
// Scoreboard bench. The stimulus process drives one clock per transaction,
// advances an arithmetic reference model and queues the values the DUT must
// show after that edge. A separate monitor pops and compares them at the
// falling edge (or just before the next rising edge for async-reset checks).
// -----------------------------------------------------------------------------
module tb_mac_act_unit;

    localparam int K_ACC = 0;
    localparam int K_CNT = 1;
    localparam int K_RD  = 2;
    localparam int K_WM  = 3;

    localparam longint ACC_HI = 64'sd8388607;
    localparam longint ACC_LO = -64'sd8388608;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        mac_clear = 1'b1;
    logic [7:0]  x_in      = 8'd0;
    logic [7:0]  w_in      = 8'd0;
    logic        relu_en   = 1'b0;
    logic [63:0] we        = 64'd0;
    logic [5:0]  rd_addr   = 6'd0;
    logic [7:0]  rd_data;
    logic [23:0] acc_out;
    logic [7:0]  mac_count;
    logic        we_multi;

    mac_act_unit dut (
        .clk       (clk),
        .rst       (rst),
        .mac_clear (mac_clear),
        .x_in      (x_in),
        .w_in      (w_in),
        .relu_en   (relu_en),
        .we        (we),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .acc_out   (acc_out),
        .mac_count (mac_count),
        .we_multi  (we_multi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        int due;
        int kind;
        int exp;
    } chk_t;

    chk_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // ---------------- reference model ----------------
    int     mbuf[64];
    longint macc;
    int     mcnt;
    bit     mwm;
    int     pend[$];   // products issued but not yet summed

    function automatic int f_act(longint a, bit relu);
        longint v;
        longint s;
        v = (relu && a < 0) ? 64'sd0 : a;
        // floor(v / 16)
        if (v >= 0) s = v / 16;
        else        s = -((-v + 15) / 16);
        if (s > 127)  return 127;
        if (s < -128) return -128;
        return int'(s);
    endfunction

    function automatic longint clamp_acc(longint s);
        if (s > ACC_HI) return ACC_HI;
        if (s < ACC_LO) return ACC_LO;
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 64; k++) mbuf[k] = 0;
        macc = 0;
        mcnt = 0;
        mwm  = 1'b0;
        pend.delete();
    endtask

    task automatic expect_val(int due, int kind, int exp);
        chk_t c;
        c.due  = due;
        c.kind = kind;
        c.exp  = exp;
        sb_q.push_back(c);
    endtask

    function automatic string kname(int kind);
        case (kind)
            K_ACC:   return "acc_out";
            K_CNT:   return "mac_count";
            K_RD:    return "rd_data";
            default: return "we_multi";
        endcase
    endfunction

    // One clock of stimulus: apply inputs, take the edge, update the model
    // and queue what the DUT must show afterwards.
    task automatic drive(bit clr, int x, int w, bit relu, logic [63:0] wev, int addr);
        int rd_exp;
        int act;
        int nw;
        mac_clear = clr;
        x_in      = x[7:0];
        w_in      = w[7:0];
        relu_en   = relu;
        we        = wev;
        rd_addr   = addr[5:0];
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
            rd_exp = 0;
        end else begin
            rd_exp = mbuf[addr];
            act    = f_act(macc, relu);
            nw     = 0;
            for (int k = 0; k < 64; k++) begin
                if (wev[k]) begin
                    mbuf[k] = act;
                    nw++;
                end
            end
            if (nw > 1) mwm = 1'b1;
            if (clr) begin
                macc = 0;
                mcnt = 0;
                pend.delete();
            end else begin
                if (pend.size() > 0) begin
                    macc = clamp_acc(macc + longint'(pend.pop_front()));
                    mcnt = (mcnt < 255) ? mcnt + 1 : 255;
                end
                pend.push_back(x * w);
            end
        end
        expect_val(2 * cyc, K_ACC, int'(macc));
        expect_val(2 * cyc, K_CNT, mcnt);
        expect_val(2 * cyc, K_RD,  rd_exp);
        expect_val(2 * cyc, K_WM,  int'(mwm));
    endtask

    task automatic idle(int addr);
        drive(1'b0, 0, 0, 1'b1, 64'd0, addr);
    endtask

    task automatic accumulate(int x, int w, int n);
        for (int i = 0; i < n; i++) drive(1'b0, x, w, 1'b0, 64'd0, 0);
    endtask

    // Raise rst between clock edges; outputs must clear before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        expect_val(2 * cyc + 1, K_ACC, 0);
        expect_val(2 * cyc + 1, K_CNT, 0);
        expect_val(2 * cyc + 1, K_RD,  0);
        expect_val(2 * cyc + 1, K_WM,  0);
    endtask

    // ---------------- monitor ----------------
    task automatic sample(int stamp);
        chk_t c;
        int   act;
        while (sb_q.size() > 0 && sb_q[0].due <= stamp) begin
            c = sb_q.pop_front();
            case (c.kind)
                K_ACC:   act = {{8{acc_out[23]}}, acc_out};
                K_CNT:   act = {24'd0, mac_count};
                K_RD:    act = {{24{rd_data[7]}}, rd_data};
                default: act = {31'd0, we_multi};
            endcase
            checks++;
            if (act != c.exp) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)",
                         kname(c.kind), act, c.exp, cyc, $time);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            sample(2 * cyc);
            #3;
            sample(2 * cyc + 1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();

        // Reset held across edges, then sweep every buffer address.
        repeat (3) drive(1'b1, 0, 0, 1'b0, 64'd0, 0);
        rst = 1'b0;
        for (int a = 0; a < 64; a++) drive(1'b1, 0, 0, 1'b0, 64'd0, a);
        expect_val(2 * cyc, K_RD, 0);
        $display("phase reset: swept 64 addresses");

        // Positive accumulation: 13 x (2*3) = 78 -> f = 4.
        drive(1'b1, 0, 0, 1'b0, 64'd0, 0);
        accumulate(2, 3, 13);
        idle(0);
        expect_val(2 * cyc, K_ACC, 78);
        expect_val(2 * cyc, K_CNT, 13);
        idle(0);
        drive(1'b0, 0, 0, 1'b1, 64'd1 << 5, 5);
        expect_val(2 * cyc, K_RD, 0);            // same-edge read sees old value
        drive(1'b0, 0, 0, 1'b1, 64'd0, 5);
        expect_val(2 * cyc, K_RD, 4);
        $display("phase positive: entry 5 written");

        // Negative accumulation: -2600, relu -> 0, no relu -> -128.
        drive(1'b1, 0, 0, 1'b0, 64'd0, 0);
        accumulate(-10, 20, 13);
        idle(0);
        expect_val(2 * cyc, K_ACC, -2600);
        idle(0);
        drive(1'b0, 0, 0, 1'b1, 64'd1 << 0, 0);
        drive(1'b0, 0, 0, 1'b0, 64'd1 << 1, 0);
        drive(1'b0, 0, 0, 1'b0, 64'd0, 0);
        expect_val(2 * cyc, K_RD, 0);
        drive(1'b0, 0, 0, 1'b0, 64'd0, 1);
        expect_val(2 * cyc, K_RD, -128);
        $display("phase negative: entries 0 and 1 written");

        // Large positive sum: 209677 -> activation clamps to 127.
        drive(1'b1, 0, 0, 1'b0, 64'd0, 0);
        accumulate(127, 127, 13);
        idle(0);
        expect_val(2 * cyc, K_ACC, 209677);
        idle(0);
        drive(1'b0, 0, 0, 1'b1, 64'd1 << 63, 63);
        drive(1'b0, 0, 0, 1'b1, 64'd0, 63);
        expect_val(2 * cyc, K_RD, 127);
        $display("phase saturate-act: entry 63 written");

        // Clear and write on the same edge.
        drive(1'b1, 0, 0, 1'b0, 64'd0, 0);
        accumulate(2, 3, 13);
        idle(0);
        idle(0);
        drive(1'b1, 0, 0, 1'b1, 64'd1 << 2, 0);
        expect_val(2 * cyc, K_ACC, 0);
        expect_val(2 * cyc, K_CNT, 0);
        drive(1'b1, 0, 0, 1'b1, 64'd0, 2);
        expect_val(2 * cyc, K_RD, 4);
        $display("phase clear-write collision");

        // Multi-bit write, sticky flag, then async reset mid-accumulation.
        drive(1'b1, 0, 0, 1'b0, 64'd0, 0);
        accumulate(2, 3, 13);
        idle(0);
        idle(0);
        drive(1'b0, 0, 0, 1'b1, 64'h3, 0);
        expect_val(2 * cyc, K_WM, 1);
        drive(1'b0, 0, 0, 1'b1, 64'd0, 0);
        expect_val(2 * cyc, K_RD, 4);
        drive(1'b0, 0, 0, 1'b1, 64'd0, 1);
        expect_val(2 * cyc, K_RD, 4);
        accumulate(5, 5, 4);
        expect_val(2 * cyc, K_WM, 1);
        async_reset();
        drive(1'b0, 7, 7, 1'b0, 64'd0, 0);
        rst = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 64'd0, 0);
        drive(1'b0, 0, 0, 1'b0, 64'd0, 1);
        expect_val(2 * cyc, K_RD, 0);
        drive(1'b0, 0, 0, 1'b0, 64'd0, 5);
        drive(1'b0, 0, 0, 1'b0, 64'd0, 63);
        expect_val(2 * cyc, K_WM, 0);
        $display("phase multi-write and async reset");

        // Accumulator saturation both ways, count saturation at 255.
        drive(1'b1, 0, 0, 1'b0, 64'd0, 0);
        accumulate(127, 127, 530);
        idle(0);
        expect_val(2 * cyc, K_ACC, 8388607);
        expect_val(2 * cyc, K_CNT, 255);
        drive(1'b1, 0, 0, 1'b0, 64'd0, 0);
        accumulate(-128, 127, 530);
        idle(0);
        expect_val(2 * cyc, K_ACC, -8388608);
        $display("phase accumulator saturation");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit          clr;
            bit          relu;
            logic [63:0] wev;
            int          x;
            int          w;
            clr  = ($urandom_range(0, 15) == 0);
            relu = $urandom_range(0, 1) == 1;
            wev  = 64'd0;
            if ($urandom_range(0, 7) == 0) wev = 64'd1 << $urandom_range(0, 63);
            x = int'($urandom_range(0, 255)) - 128;
            w = int'($urandom_range(0, 255)) - 128;
            drive(clr, x, w, relu, wev, int'($urandom_range(0, 63)));
        end
        $display("phase random: 400 transactions");

        idle(0);
        @(negedge clk);
        #4;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_act_unit.md
# mac_act_unit

Datapath stage that consumes the controller's `MACreset` and one-hot `we[63:0]` strobes. It multiplies each input/weight operand pair, accumulates the products, and applies ReLU plus requantization. The result is written into a 64-entry activation buffer, which is the hidden-layer store read back in the next round. It sits between the input/weight memories (addressed by the controller's `INaddr`/`Waddr`) and the round-1 input path.

## Interface
- `DATA_W`, 8: signed operand and activation width.
- `ACC_W`, 24: signed accumulator width.
- `FRAC_SHIFT`, 4: arithmetic right shift applied at requantization.
- `NUM_ENT`, 64: activation buffer depth; equals the width of `we`.

Ports:
- `clk`  in  1: the single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `mac_clear`  in  1: driven by controller `MACreset`; synchronous clear of the pipeline and accumulator.
- `x_in`  in  DATA_W: signed activation operand.
- `w_in`  in  DATA_W: signed weight operand.
- `relu_en`  in  1: 1 applies ReLU before requantization.
- `we`  in  NUM_ENT: one-hot write strobe into the buffer.
- `rd_addr`  in  6: buffer read address.
- `rd_data`  out  DATA_W: registered buffer read data.
- `acc_out`  out  ACC_W: current accumulator register value (debug).
- `mac_count`  out  8: number of products accumulated since the last clear; saturates at 255.
- `we_multi`  out  1: sticky error flag, set when more than one `we` bit is high.

## Operation
- Stage P: `prod <= x_in * w_in`, full 2*DATA_W signed width. `prod_v <= ~mac_clear`.
- Stage A: when `prod_v` is 1 and `mac_clear` is 0, `acc <= sat_ACC(acc + sext(prod))`. `mac_count` increments, saturating at 255.
- Accumulator saturation: the sum clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. It never wraps.
- `mac_clear` = 1 at an edge: `prod`, `prod_v`, `acc` and `mac_count` all become 0. No accumulation occurs on that edge.
- Activation function f(acc):
  - If `relu_en` = 1, take v = max(acc, 0); otherwise v = acc.
  - Compute s = v >>> FRAC_SHIFT (arithmetic shift, floor toward -inf).
  - Saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Buffer write: on an edge where `we[k]` = 1, `buf[k] <= f(acc)`, using the accumulator value before that edge.
- Multiple `we` bits high: every selected entry receives the same f(acc), and `we_multi` is set. `we_multi` stays set until `rst`.
- Read: `rd_data <= buf[rd_addr]` every cycle.

## Timing
- Reset (async, immediate): `acc_out`=0, `mac_count`=0, `rd_data`=0, `we_multi`=0, `prod`/`prod_v`=0, all 64 buffer entries = 0.
- Operand-to-accumulator latency is 2 edges: operands present at edge N are in `prod` after N and in `acc` after N+1.
- `we` must be asserted no earlier than the second edge after the last operand cycle. The controller's two drain states satisfy this.
- An earlier `we` writes a partial sum. This is not detected.
- `mac_clear` and `we` on the same edge: the buffer receives f(acc) computed from the pre-clear value, and `acc` becomes 0.
- `mac_clear` and valid operands on the same edge: the operands are discarded.
- Read latency is 1 edge.
- Read and write of the same entry on the same edge: `rd_data` returns the old value; the new value is visible one edge later.
- `rst` asserted mid-accumulation: everything returns to reset values immediately. After release, the first operands are accepted on the next edge where `mac_clear` = 0.

## Test plan
- Reset check: pulse `rst`, then sweep `rd_addr` 0..63. Required: `rd_data`=0 for every address, `acc_out`=0, `mac_count`=0, `we_multi`=0.
- Positive accumulation: `mac_clear`=0, 13 cycles of x=2, w=3, then 2 idle cycles, then `we`=1<<5 with `relu_en`=1. Required: `acc_out`=78 and `mac_count`=13; reading `rd_addr`=5 gives `rd_data`=4 one edge later.
- Negative accumulation: 13 cycles of x=-10, w=20, giving `acc_out`=-2600.
  - With `relu_en`=1, a write to entry 0 stores 0.
  - With `relu_en`=0, a write to entry 1 stores -128 (-163 saturated).
- Positive saturation: 13 cycles of x=127, w=127, giving `acc_out`=209677. A write to entry 63 stores 127.
- Clear/write collision: accumulate to 78, then assert `mac_clear` and `we`=1<<2 on the same edge. Required: entry 2 = 4, `acc_out`=0, `mac_count`=0 after that edge.
- Multi-write and async reset:
  - `we`=0x3 with `acc`=78: entries 0 and 1 both become 4, and `we_multi`=1 and stays 1.
  - Asserting `rst` mid-accumulation clears `we_multi`, `acc_out` and the buffer without waiting for a clock edge.
